// File: rtl/prbs_transmitter.sv
// PRBS7 serial transmitter (x^7 + x^6 + 1) with one-shot and periodic error
// injection, saturating bit/error counters and periodic count snapshots.
module prbs_transmitter #(
    parameter int unsigned BIT_DIV       = 1,
    parameter logic [6:0]  SEED          = 7'h7F,
    parameter int unsigned SNAP_INTERVAL = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load_seed,
    input  logic [6:0]  seed_in,
    input  logic        inject_err,
    input  logic [15:0] err_period,
    output logic        bit_out,
    output logic        bit_valid,
    output logic [6:0]  lfsr_state,
    output logic [31:0] tx_bits_out,
    output logic [31:0] inj_errs_out,
    output logic        snap_valid
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [15:0] DIV_LAST  = 16'(BIT_DIV - 1);
    localparam logic [23:0] SNAP_LAST = 24'(SNAP_INTERVAL - 1);

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    state_t      state_q, state_d;
    logic [15:0] div_q, div_d;
    logic [6:0]  lfsr_q, lfsr_d;
    logic        bit_out_q, bit_out_d;
    logic        bit_valid_q, bit_valid_d;
    logic        pend_q, pend_d;
    logic [15:0] per_cnt_q, per_cnt_d;
    logic [15:0] per_reg_q, per_reg_d;
    logic [31:0] tx_bits_q, tx_bits_d;
    logic [31:0] inj_errs_q, inj_errs_d;
    logic [23:0] snap_cnt_q, snap_cnt_d;
    logic [31:0] tx_snap_q, tx_snap_d;
    logic [31:0] inj_snap_q, inj_snap_d;
    logic        snap_valid_q, snap_valid_d;

    logic tick;
    logic fb_bit;
    logic per_changed;
    logic per_hit;
    logic inv;

    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        lfsr_d       = lfsr_q;
        bit_out_d    = bit_out_q;
        bit_valid_d  = 1'b0;
        pend_d       = pend_q | inject_err;
        per_cnt_d    = per_cnt_q;
        per_reg_d    = err_period;
        tx_bits_d    = tx_bits_q;
        inj_errs_d   = inj_errs_q;
        snap_cnt_d   = snap_cnt_q;
        tx_snap_d    = tx_snap_q;
        inj_snap_d   = inj_snap_q;
        snap_valid_d = 1'b0;

        state_d = en ? RUN : IDLE;

        tick   = (state_q == RUN) && (div_q == DIV_LAST);
        fb_bit = lfsr_q[6] ^ lfsr_q[5];

        // A new err_period restarts the bit counter; no periodic hit that cycle.
        per_changed = (err_period != per_reg_q);
        per_hit     = !per_changed && (err_period != 16'd0) &&
                      ((per_cnt_q + 16'd1) == err_period);
        inv         = pend_q | inject_err | per_hit;

        if (state_q == RUN) begin
            div_d = tick ? 16'd0 : div_q + 16'd1;
        end else begin
            div_d = 16'd0;
        end

        if (per_changed) begin
            per_cnt_d = 16'd0;
        end

        // Seed load wins over a coincident tick, which is simply dropped.
        if (load_seed) begin
            lfsr_d     = (seed_in == 7'd0) ? 7'h01 : seed_in;
            div_d      = 16'd0;
            pend_d     = 1'b0;
            per_cnt_d  = 16'd0;
            tx_bits_d  = 32'd0;
            inj_errs_d = 32'd0;
        end else if (tick) begin
            lfsr_d      = {lfsr_q[5:0], fb_bit};
            bit_out_d   = fb_bit ^ inv;
            bit_valid_d = 1'b1;
            pend_d      = 1'b0;
            tx_bits_d   = sat_inc(tx_bits_q);
            if (inv) begin
                inj_errs_d = sat_inc(inj_errs_q);
            end
            if (!per_changed && (err_period != 16'd0)) begin
                per_cnt_d = per_hit ? 16'd0 : per_cnt_q + 16'd1;
            end
        end

        // Snapshot captures the counters as they stood before this cycle's update.
        if (snap_cnt_q == SNAP_LAST) begin
            snap_cnt_d   = 24'd0;
            tx_snap_d    = tx_bits_q;
            inj_snap_d   = inj_errs_q;
            snap_valid_d = 1'b1;
        end else begin
            snap_cnt_d = snap_cnt_q + 24'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            div_q        <= 16'd0;
            lfsr_q       <= SEED;
            bit_out_q    <= 1'b0;
            bit_valid_q  <= 1'b0;
            pend_q       <= 1'b0;
            per_cnt_q    <= 16'd0;
            per_reg_q    <= 16'd0;
            tx_bits_q    <= 32'd0;
            inj_errs_q   <= 32'd0;
            snap_cnt_q   <= 24'd0;
            tx_snap_q    <= 32'd0;
            inj_snap_q   <= 32'd0;
            snap_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            lfsr_q       <= lfsr_d;
            bit_out_q    <= bit_out_d;
            bit_valid_q  <= bit_valid_d;
            pend_q       <= pend_d;
            per_cnt_q    <= per_cnt_d;
            per_reg_q    <= per_reg_d;
            tx_bits_q    <= tx_bits_d;
            inj_errs_q   <= inj_errs_d;
            snap_cnt_q   <= snap_cnt_d;
            tx_snap_q    <= tx_snap_d;
            inj_snap_q   <= inj_snap_d;
            snap_valid_q <= snap_valid_d;
        end
    end

    assign bit_out      = bit_out_q;
    assign bit_valid    = bit_valid_q;
    assign lfsr_state   = lfsr_q;
    assign tx_bits_out  = tx_snap_q;
    assign inj_errs_out = inj_snap_q;
    assign snap_valid   = snap_valid_q;

endmodule
